spi_flash_responder: RTL and testbench
======================================

Name: spi_flash_responder

Overview:
Synthesizable SPI flash responder, mode 0, MSB first. It is the slave-side counterpart to spi_master's RDID transaction. It answers RDID (0x9F) with a 3-byte JEDEC ID and RDSR (0x05) with a repeating status byte. All SPI pins are oversampled in the system clock domain. It serves as an on-chip loopback target for the RDID board design and as a synthesizable bench model for spi_master.

Parameters:
MFG_ID, 8'h20, manufacturer ID byte, first RDID byte.
MEM_TYPE, 8'h20, memory type byte, second RDID byte.
MEM_CAPACITY, 8'h15, capacity byte, third RDID byte.
STATUS, 8'h00, byte returned repeatedly by RDSR.

Ports:
clk  in  1  system clock; all logic on rising edge.
reset_n  in  1  asynchronous, active-low reset.
SPICLK  in  1  SPI clock from master; idles low.
SPIMOSI  in  1  master-out serial data.
chip_select  in  1  active-low frame select.
SPIMISO  out  1  slave-out serial data.
miso_oe  out  1  high while responder drives meaningful data (RDID/RDSR response states).
cmd_valid  out  1  one-clk pulse when a full command byte is received.
cmd_byte  out  8  last complete command byte; held until the next one.
frame_active  out  1  high from detected CS fall to detected CS rise.
rdid_count  out  8  number of RDID commands decoded; wraps 255->0.

Behaviour:
- Synchronization: SPICLK, SPIMOSI and chip_select each pass through a 2-FF synchronizer, plus one delay stage for edge detection.
  - Sync flops reset to SPICLK=0, MOSI=0, CS=0 (asserted). A frame therefore starts only on a real CS high->low transition seen after reset.
- Timing constraints: SPICLK period >= 8 clk. CS fall to first SPICLK rise >= 4 clk.
- Reset values: SPIMISO=0, miso_oe=0, cmd_valid=0, cmd_byte=8'h00, frame_active=0, rdid_count=0, state=IDLE.
- FSM states: IDLE, CMD, RESP_RDID, RESP_RDSR, IGNORE.
- IDLE -> CMD on detected CS fall. Clear the 3-bit bit counter and the command shift register; frame_active=1.
- CMD:
  - Each detected SPICLK rise shifts the synced MOSI into the LSB.
  - On the 8th rise: cmd_byte<=shifted value; pulse cmd_valid for 1 clk.
  - 0x9F -> RESP_RDID: load 24-bit shift register {MFG_ID,MEM_TYPE,MEM_CAPACITY}; rdid_count+1.
  - 0x05 -> RESP_RDSR: load STATUS.
  - Any other byte -> IGNORE.
- RESP_RDID:
  - miso_oe=1.
  - On each detected SPICLK fall, drive SPIMISO = shift register MSB, then rotate left by 1.
  - The first fall after the 8th command rise presents bit 23. Every later fall presents the next bit.
  - After 24 bits the rotation wraps, so the ID repeats for as long as clocks continue.
  - SPIMISO update lag <= 4 clk after the SPICLK fall.
- RESP_RDSR: same mechanism as RESP_RDID with an 8-bit rotation of STATUS; it repeats indefinitely.
- IGNORE: SPIMISO=0, miso_oe=0; SPICLK edges ignored.
- CS rise in any state (detected):
  - Next state IDLE; SPIMISO=0, miso_oe=0, frame_active=0.
  - A partial command (<8 bits) is discarded: no cmd_valid, cmd_byte unchanged.
- SPICLK edges while in IDLE are ignored.
- A CS rise and an SPICLK edge detected in the same clk: the CS rise wins; the SPICLK edge is dropped.
- reset_n low mid-frame: immediate return to reset values. After release, the frame in progress is ignored until CS goes high and then low again.

Test Plan:
1. Reset, CS low, send 0x9F, then 24 clocks -> cmd_valid pulses once, cmd_byte=0x9F, MISO bytes 0x20,0x20,0x15, rdid_count=1, miso_oe high during the response.
2. RDID with 48 response clocks -> 0x20,0x20,0x15,0x20,0x20,0x15; CS rise -> SPIMISO=0, frame_active=0 within 4 clk.
3. STATUS=8'hA5, send 0x05 then 16 clocks -> MISO 0xA5,0xA5; rdid_count unchanged.
4. Send 0x03 then 16 clocks -> cmd_byte=0x03, cmd_valid once, SPIMISO=0 and miso_oe=0 throughout.
5. CS low, 5 bits of 0x9F, CS high, then a full RDID frame -> no cmd_valid for the aborted frame; the second frame returns 0x20,0x20,0x15; rdid_count=1.
6. Assert reset_n mid-RDID-response while CS stays low, release, keep clocking -> SPIMISO=0, rdid_count=0, no cmd_valid. After CS high, a new frame with 0x9F returns the correct ID.

Source files
------------

// File: rtl/spi_flash_responder.sv
// SPI mode-0 flash responder: answers RDID (0x9F) with a rotating 3-byte JEDEC ID
// and RDSR (0x05) with a rotating status byte. All SPI pins are oversampled on clk.
//
// state     | meaning
// IDLE      | no frame; waiting for a CS fall
// CMD       | shifting in the 8-bit command
// RESP_RDID | rotating {MFG_ID, MEM_TYPE, MEM_CAPACITY} out on SPICLK falls
// RESP_RDSR | rotating STATUS out on SPICLK falls
// IGNORE    | unknown command; outputs quiet until CS rises
module spi_flash_responder #(
    parameter logic [7:0] MFG_ID       = 8'h20,
    parameter logic [7:0] MEM_TYPE     = 8'h20,
    parameter logic [7:0] MEM_CAPACITY = 8'h15,
    parameter logic [7:0] STATUS       = 8'h00
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       SPICLK,
    input  logic       SPIMOSI,
    input  logic       chip_select,
    output logic       SPIMISO,
    output logic       miso_oe,
    output logic       cmd_valid,
    output logic [7:0] cmd_byte,
    output logic       frame_active,
    output logic [7:0] rdid_count
);

    typedef enum logic [2:0] {IDLE, CMD, RESP_RDID, RESP_RDSR, IGNORE} state_t;

    state_t      state, state_nx;
    logic [2:0]  sclk_sync, cs_sync;
    logic [1:0]  mosi_sync;
    logic [2:0]  bit_cnt;
    logic [7:0]  cmd_sr;
    logic [23:0] resp_sr;

    // Stage [1] is the synchronized level, stage [2] the delayed copy for edges.
    // CS resets to "asserted" so a frame needs a real high->low after reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sclk_sync <= 3'b000;
            cs_sync   <= 3'b000;
            mosi_sync <= 2'b00;
        end else begin
            sclk_sync <= {sclk_sync[1:0], SPICLK};
            cs_sync   <= {cs_sync[1:0], chip_select};
            mosi_sync <= {mosi_sync[0], SPIMOSI};
        end
    end

    logic       sclk_rise, sclk_fall, cs_rise, cs_fall, last_bit;
    logic [7:0] cmd_next;

    assign sclk_rise = sclk_sync[1] & ~sclk_sync[2];
    assign sclk_fall = ~sclk_sync[1] & sclk_sync[2];
    assign cs_rise   = cs_sync[1] & ~cs_sync[2];
    assign cs_fall   = ~cs_sync[1] & cs_sync[2];
    assign cmd_next  = {cmd_sr[6:0], mosi_sync[1]};
    assign last_bit  = sclk_rise && (bit_cnt == 3'd7);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (cs_rise) begin
            state_nx = IDLE;
        end else begin
            case (state)
                IDLE: if (cs_fall) state_nx = CMD;
                CMD: begin
                    if (last_bit) begin
                        if (cmd_next == 8'h9F)      state_nx = RESP_RDID;
                        else if (cmd_next == 8'h05) state_nx = RESP_RDSR;
                        else                        state_nx = IGNORE;
                    end
                end
                default: ;
            endcase
        end
    end

    assign miso_oe      = (state == RESP_RDID) || (state == RESP_RDSR);
    assign frame_active = (state != IDLE);

    // RDSR reuses the 24-bit rotator with STATUS replicated, giving an 8-bit period.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            SPIMISO    <= 1'b0;
            cmd_valid  <= 1'b0;
            cmd_byte   <= 8'h00;
            rdid_count <= 8'h00;
            bit_cnt    <= 3'd0;
            cmd_sr     <= 8'h00;
            resp_sr    <= 24'h0;
        end else begin
            cmd_valid <= 1'b0;
            if (cs_rise) begin
                SPIMISO <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (cs_fall) begin
                            bit_cnt <= 3'd0;
                            cmd_sr  <= 8'h00;
                            SPIMISO <= 1'b0;
                        end
                    end
                    CMD: begin
                        if (sclk_rise) begin
                            cmd_sr  <= cmd_next;
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                        if (last_bit) begin
                            cmd_byte  <= cmd_next;
                            cmd_valid <= 1'b1;
                            if (cmd_next == 8'h9F) begin
                                resp_sr    <= {MFG_ID, MEM_TYPE, MEM_CAPACITY};
                                rdid_count <= rdid_count + 8'd1;
                            end else if (cmd_next == 8'h05) begin
                                resp_sr <= {STATUS, STATUS, STATUS};
                            end
                        end
                    end
                    RESP_RDID, RESP_RDSR: begin
                        if (sclk_fall) begin
                            SPIMISO <= resp_sr[23];
                            resp_sr <= {resp_sr[22:0], resp_sr[23]};
                        end
                    end
                    default: SPIMISO <= 1'b0;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_flash_responder.sv
// Directed bench for spi_flash_responder acting as an SPI mode-0 master, with a
// queue of expected response bytes checked as each byte is clocked back.
module tb_spi_flash_responder;

    logic       clk = 1'b0;
    logic       reset_n, SPICLK, SPIMOSI, chip_select;
    logic       SPIMISO, miso_oe, cmd_valid, frame_active;
    logic [7:0] cmd_byte, rdid_count;

    spi_flash_responder #(
        .MFG_ID(8'h20), .MEM_TYPE(8'h20), .MEM_CAPACITY(8'h15), .STATUS(8'hA5)
    ) dut (
        .clk(clk), .reset_n(reset_n), .SPICLK(SPICLK), .SPIMOSI(SPIMOSI),
        .chip_select(chip_select), .SPIMISO(SPIMISO), .miso_oe(miso_oe),
        .cmd_valid(cmd_valid), .cmd_byte(cmd_byte), .frame_active(frame_active),
        .rdid_count(rdid_count)
    );

    always #5 clk = ~clk;

    int         total = 0;
    int         bad = 0;
    int         cv_count = 0;
    int         cv0;
    logic       watch = 1'b0;
    logic       seen_bad = 1'b0;
    logic [7:0] exp_q[$];
    logic [7:0] rx;
    logic [7:0] exp_rdid = 8'd0;

    always @(negedge clk) begin
        if (cmd_valid === 1'b1) cv_count++;
        if (watch && (SPIMISO !== 1'b0 || miso_oe !== 1'b0)) seen_bad = 1'b1;
    end

    task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One SPI bit: MOSI set, half period, sample MISO, rise, half period, fall.
    task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] r);
        r = 8'h00;
        for (int i = 0; i < n; i++) begin
            SPIMOSI = tx[7-i];
            wait_clk(8);
            r = {r[6:0], SPIMISO};
            SPICLK = 1'b1;
            wait_clk(8);
            SPICLK = 1'b0;
        end
    endtask

    task automatic resp_bytes(input int n, input string tag);
        logic [7:0] r, e;
        for (int i = 0; i < n; i++) begin
            spi_bits(8'h00, 8, r);
            if (exp_q.size() == 0) begin
                chk({tag, "_queue_empty"}, 24'd1, 24'd0);
            end else begin
                e = exp_q.pop_front();
                chk(tag, {16'h0, r}, {16'h0, e});
            end
        end
    endtask

    task automatic cs_low();
        chip_select = 1'b0;
        wait_clk(8);
    endtask

    task automatic cs_high();
        chip_select = 1'b1;
        wait_clk(8);
    endtask

    task automatic push_id();
        exp_q.push_back(8'h20);
        exp_q.push_back(8'h20);
        exp_q.push_back(8'h15);
    endtask

    initial begin
        reset_n = 1'b0; SPICLK = 1'b0; SPIMOSI = 1'b0; chip_select = 1'b1;
        wait_clk(5);
        chk("rst_miso", SPIMISO, 0);
        chk("rst_oe", miso_oe, 0);
        chk("rst_cv", cmd_valid, 0);
        chk("rst_cmd", cmd_byte, 0);
        chk("rst_frame", frame_active, 0);
        chk("rst_rdid", rdid_count, 0);
        reset_n = 1'b1;
        wait_clk(8);

        // 1: basic RDID
        cs_low();
        chk("t1_frame", frame_active, 1);
        cv0 = cv_count;
        spi_bits(8'h9F, 8, rx);
        push_id(); exp_rdid++;
        chk("t1_oe", miso_oe, 1);
        resp_bytes(3, "t1_id");
        chk("t1_cv_once", cv_count - cv0, 1);
        chk("t1_cmd", cmd_byte, 8'h9F);
        chk("t1_rdid", rdid_count, exp_rdid);
        cs_high();
        chk("t1_end_oe", miso_oe, 0);

        // 2: ID wraps over 48 clocks, CS rise quiets outputs within 4 clk
        cs_low();
        spi_bits(8'h9F, 8, rx);
        push_id(); push_id(); exp_rdid++;
        resp_bytes(6, "t2_id");
        chip_select = 1'b1;
        wait_clk(4);
        chk("t2_miso", SPIMISO, 0);
        chk("t2_frame", frame_active, 0);
        chk("t2_oe", miso_oe, 0);
        wait_clk(4);

        // 3: RDSR repeats STATUS
        cs_low();
        spi_bits(8'h05, 8, rx);
        exp_q.push_back(8'hA5); exp_q.push_back(8'hA5);
        chk("t3_oe", miso_oe, 1);
        resp_bytes(2, "t3_sr");
        chk("t3_rdid", rdid_count, exp_rdid);
        chk("t3_cmd", cmd_byte, 8'h05);
        cs_high();

        // 4: unknown command, outputs quiet throughout
        seen_bad = 1'b0; watch = 1'b1;
        cs_low();
        cv0 = cv_count;
        spi_bits(8'h03, 8, rx);
        exp_q.push_back(8'h00); exp_q.push_back(8'h00);
        resp_bytes(2, "t4_quiet");
        chk("t4_cmd", cmd_byte, 8'h03);
        chk("t4_cv_once", cv_count - cv0, 1);
        chk("t4_no_drive", seen_bad, 0);
        cs_high();
        watch = 1'b0;

        // 5: aborted partial command, then full RDID
        cs_low();
        cv0 = cv_count;
        spi_bits(8'h9F, 5, rx);
        cs_high();
        chk("t5_abort_cv", cv_count - cv0, 0);
        chk("t5_abort_cmd", cmd_byte, 8'h03);
        chk("t5_abort_rdid", rdid_count, exp_rdid);
        cs_low();
        spi_bits(8'h9F, 8, rx);
        push_id(); exp_rdid++;
        resp_bytes(3, "t5_id");
        chk("t5_rdid", rdid_count, exp_rdid);
        cs_high();

        // 6: reset mid-response with CS held low
        cs_low();
        spi_bits(8'h9F, 8, rx);
        push_id();
        resp_bytes(1, "t6_pre");
        reset_n = 1'b0;
        exp_q.delete();
        exp_rdid = 8'd0;
        wait_clk(3);
        chk("t6_rst_miso", SPIMISO, 0);
        chk("t6_rst_rdid", rdid_count, 0);
        chk("t6_rst_oe", miso_oe, 0);
        reset_n = 1'b1;
        seen_bad = 1'b0; watch = 1'b1;
        cv0 = cv_count;
        spi_bits(8'h9F, 8, rx);
        spi_bits(8'h00, 8, rx);
        chk("t6_no_drive", seen_bad, 0);
        chk("t6_no_cv", cv_count - cv0, 0);
        chk("t6_rdid_zero", rdid_count, 0);
        chk("t6_frame", frame_active, 0);
        watch = 1'b0;
        cs_high();
        cs_low();
        spi_bits(8'h9F, 8, rx);
        push_id(); exp_rdid++;
        resp_bytes(3, "t6_id");
        chk("t6_rdid", rdid_count, exp_rdid);
        cs_high();
        chk("sb_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
